mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single word-wide memory port between the instruction-fetch requester and the load/store requester of the RISC-V core. Each cycle it picks at most one requester and drives the memory's address/write_data/write_enable. It captures the combinational read data into a registered response one cycle later. Data accesses have priority; a bounded starvation counter guarantees fetch progress. It also rejects misaligned and out-of-range accesses before they reach memory.

Parameters:
MEM_WORDS, 255, number of valid memory words; word index must be < MEM_WORDS
STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting (>=1)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
if_req_valid  input  1  fetch request present
if_req_addr  input  32  fetch byte address
if_req_ready  output  1  fetch request accepted this cycle
if_rsp_valid  output  1  fetch response valid (one-cycle pulse)
if_rsp_data  output  32  fetched word
if_rsp_err  output  1  fetch was misaligned or out of range
d_req_valid  input  1  data request present
d_req_addr  input  32  data byte address
d_req_we  input  1  1 = store, 0 = load
d_req_wdata  input  32  store data
d_req_ready  output  1  data request accepted this cycle
d_rsp_valid  output  1  data response valid (one-cycle pulse; loads and stores)
d_rsp_data  output  32  load data; 0 for stores and errors
d_rsp_err  output  1  access rejected
mem_address  output  32  to memory address
mem_write_data  output  32  to memory write_data
mem_write_enable  output  1  to memory write_enable
mem_read_data  input  32  from memory read_data (combinational read)

Behaviour:
- Reset: sync, active-high. While rst=1: both ready=0, mem_write_enable=0, all rsp_valid/rsp_err=0, rsp_data=0, starve counter=0. A response pending at reset assertion is dropped.
- Grant (combinational, same cycle): both valid -> data wins unless starve_cnt==STARVE_LIMIT, then fetch wins. One valid -> that one wins. Winner gets ready=1; loser ready=0.
- Requester holds valid/addr/we/wdata stable until ready. Responses cannot be back-pressured.
- mem_address = winner addr (0 when no grant). mem_write_enable = 1 only for a granted, legal data store.
- Legality: addr[1:0]==0 and addr[31:2] < MEM_WORDS. Illegal -> no write, response next cycle with err=1, data=0.
- Latency: grant at cycle N -> rsp_valid=1 at N+1 exactly one cycle. rsp_data is registered from mem_read_data at posedge N (legal loads/fetches). Throughput: one access per cycle.
- Store then load to same address in consecutive cycles returns the new value (write commits at posedge N).
- Starve counter: increments on a data grant while if_req_valid=1. Clears on fetch grant or when if_req_valid=0. Saturates at STARVE_LIMIT.
- Arbitration state encoded as a 2-state FSM: DATA_PRIO (counter < limit) and FETCH_PRIO (counter == limit). FETCH_PRIO -> DATA_PRIO on fetch grant or when fetch is withdrawn.
- rsp_valid for a requester is never high in a cycle without a grant at N-1.

Decomposition:
- Shared package riscv_structures: requester enum (REQ_NONE, REQ_IF, REQ_DATA), arbitration state enum, and the alignment-mask constant.
- One sub-module mem_arb_pick: combinational winner selection from the valids and the FSM state. Counter, legality check and response registers stay in the top.

Test Plan:
- Memory preloaded mem[0..3]=DEADBEEF,12345678,ABCDEF01,FEDCBA98; fetch-only addr 0x0 -> if_req_ready at N; if_rsp_valid=1, data 0xDEADBEEF at N+1.
- Fetch 0x4 and load 0x8 both valid at N -> data granted N (d_rsp 0xABCDEF01 at N+1); fetch granted N+1 (if_rsp 0x12345678 at N+2).
- STARVE_LIMIT=4, data valid every cycle, fetch valid -> 4 data grants, fetch granted on 5th cycle, then data resumes.
- Store 0x00000005 to 0x50 at N, load 0x50 at N+1 -> d_rsp_data=5 at N+2. Misaligned store to 0x52 -> d_rsp_err=1, mem_write_enable stays 0, mem[20] unchanged.
- Load 0x3FC (index 255 with MEM_WORDS=255) -> d_rsp_err=1, d_rsp_data=0.
- Grant fetch at N, rst=1 at N+1 -> if_rsp_valid=0 at N+1 and N+2, counter=0, ready=0 during reset.

Source files
------------

// File: rtl/riscv_structures.sv
// Types and constants shared by the memory port arbiter and its winner-select logic.
package riscv_structures;

  typedef enum logic [1:0] {REQ_NONE, REQ_IF, REQ_DATA} req_e;

  typedef enum logic {DATA_PRIO, FETCH_PRIO} arb_state_e;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
module mem_arb_pick
  import riscv_structures::*;
(
  input  logic       if_valid,
  input  logic       d_valid,
  input  arb_state_e state,
  output req_e       winner
);

  always_comb begin
    winner = REQ_NONE;
    if (if_valid && d_valid) begin
      winner = (state == FETCH_PRIO) ? REQ_IF : REQ_DATA;
    end else if (d_valid) begin
      winner = REQ_DATA;
    end else if (if_valid) begin
      winner = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between instruction fetch and load/store,
// with data priority, a starvation bound for fetch, and legality filtering.
module mem_port_arbiter
  import riscv_structures::*;
#(
  parameter int unsigned MEM_WORDS    = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  arb_state_e      state_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  req_e            pick, winner;
  logic [31:0]     sel_addr;
  logic            legal;

  logic        if_rsp_valid_q, if_rsp_err_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0] if_rsp_data_q, d_rsp_data_q;

  mem_arb_pick u_pick (
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .state    (state_q),
    .winner   (pick)
  );

  always_comb begin
    winner = rst ? REQ_NONE : pick;
    case (winner)
      REQ_IF:   sel_addr = if_req_addr;
      REQ_DATA: sel_addr = d_req_addr;
      default:  sel_addr = '0;
    endcase
    legal = ((sel_addr & ALIGN_MASK) == '0) && (sel_addr[31:2] < 30'(MEM_WORDS));
  end

  assign if_req_ready     = (winner == REQ_IF);
  assign d_req_ready      = (winner == REQ_DATA);
  assign mem_address      = sel_addr;
  assign mem_write_data   = (winner == REQ_DATA) ? d_req_wdata : '0;
  assign mem_write_enable = (winner == REQ_DATA) && d_req_we && legal;

  // Count consecutive data wins only while fetch is actually waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (winner == REQ_IF || !if_req_valid) begin
      cnt_d = '0;
    end else if (winner == REQ_DATA && cnt_q != Limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DATA_PRIO;
      cnt_q          <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= (cnt_d == Limit) ? FETCH_PRIO : DATA_PRIO;
      if_rsp_valid_q <= (winner == REQ_IF);
      if_rsp_err_q   <= (winner == REQ_IF) && !legal;
      if_rsp_data_q  <= (winner == REQ_IF && legal) ? mem_read_data : '0;
      d_rsp_valid_q  <= (winner == REQ_DATA);
      d_rsp_err_q    <= (winner == REQ_DATA) && !legal;
      d_rsp_data_q   <= (winner == REQ_DATA && legal && !d_req_we) ? mem_read_data : '0;
    end
  end

  // Responses are masked while reset is held so a pending one never escapes.
  assign if_rsp_valid = if_rsp_valid_q && !rst;
  assign if_rsp_err   = if_rsp_err_q && !rst;
  assign if_rsp_data  = rst ? '0 : if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q && !rst;
  assign d_rsp_err    = d_rsp_err_q && !rst;
  assign d_rsp_data   = rst ? '0 : d_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbitration model pushes
// expected responses on each grant, which are popped when responses appear.
module tb_mem_port_arbiter;

  localparam int unsigned StarveLimit = 4;
  localparam int unsigned MemWords    = 255;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_wdata = '0;
  logic        d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  logic [31:0] mem  [0:255];
  logic [31:0] gold [0:255];
  rsp_t        if_q[$];
  rsp_t        d_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  bit          g_if, g_d;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:2]];

  mem_port_arbiter #(
    .MEM_WORDS    (MemWords),
    .STARVE_LIMIT (StarveLimit)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_valid     (if_req_valid),
    .if_req_addr      (if_req_addr),
    .if_req_ready     (if_req_ready),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_data      (if_rsp_data),
    .if_rsp_err       (if_rsp_err),
    .d_req_valid      (d_req_valid),
    .d_req_addr       (d_req_addr),
    .d_req_we         (d_req_we),
    .d_req_wdata      (d_req_wdata),
    .d_req_ready      (d_req_ready),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_data       (d_rsp_data),
    .d_rsp_err        (d_rsp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(MemWords));
  endfunction

  function automatic rsp_t expect_access(input logic [31:0] a, input bit we,
                                         input logic [31:0] wd);
    rsp_t r;
    r.err  = !legal(a);
    r.data = '0;
    if (legal(a)) begin
      if (we) gold[a[9:2]] = wd;
      else    r.data = gold[a[9:2]];
    end
    return r;
  endfunction

  // One clock: check outputs at the falling edge, then commit memory writes.
  task automatic step();
    rsp_t        e;
    bit          we_s;
    logic [31:0] a_s, wd_s;
    @(negedge clk);
    if (rst) begin
      check("if_rsp_valid_rst", 32'(if_rsp_valid), 32'd0);
      check("d_rsp_valid_rst", 32'(d_rsp_valid), 32'd0);
      check("if_rsp_data_rst", if_rsp_data, 32'd0);
      check("if_ready_rst", 32'(if_req_ready), 32'd0);
      check("d_ready_rst", 32'(d_req_ready), 32'd0);
      check("mem_we_rst", 32'(mem_write_enable), 32'd0);
      if_q.delete();
      d_q.delete();
      m_cnt = 0;
      g_if  = 1'b0;
      g_d   = 1'b0;
    end else begin
      check("if_rsp_valid", 32'(if_rsp_valid), 32'(if_q.size() != 0));
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        check("if_rsp_data", if_rsp_data, e.data);
        check("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
      end
      check("d_rsp_valid", 32'(d_rsp_valid), 32'(d_q.size() != 0));
      if (d_q.size() != 0) begin
        e = d_q.pop_front();
        check("d_rsp_data", d_rsp_data, e.data);
        check("d_rsp_err", 32'(d_rsp_err), 32'(e.err));
      end
      g_d  = d_req_valid && !(if_req_valid && m_cnt == int'(StarveLimit));
      g_if = if_req_valid && !g_d;
      check("if_ready", 32'(if_req_ready), 32'(g_if));
      check("d_ready", 32'(d_req_ready), 32'(g_d));
      check("mem_we", 32'(mem_write_enable), 32'(g_d && d_req_we && legal(d_req_addr)));
      if (g_if) begin
        check("mem_addr_if", mem_address, if_req_addr);
        if_q.push_back(expect_access(if_req_addr, 1'b0, '0));
      end
      if (g_d) begin
        check("mem_addr_d", mem_address, d_req_addr);
        d_q.push_back(expect_access(d_req_addr, d_req_we, d_req_wdata));
      end
      if (g_d && if_req_valid) m_cnt = (m_cnt == int'(StarveLimit)) ? m_cnt : m_cnt + 1;
      else                     m_cnt = 0;
    end
    we_s = mem_write_enable;
    a_s  = mem_address;
    wd_s = mem_write_data;
    @(posedge clk);
    if (we_s) mem[a_s[9:2]] = wd_s;
    #1;
  endtask

  task automatic data_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    step();
    d_req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 254)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 254)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) return 32'h0000_03FC;
    else             return 32'h8000_0000;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0;
      gold[i] = 32'h0;
    end
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h12345678;
    mem[2] = 32'hABCDEF01; mem[3] = 32'hFEDCBA98;
    for (int i = 0; i < 4; i++) gold[i] = mem[i];

    // Reset with both requesters asking: nothing may be granted.
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    step();
    step();
    rst          = 1'b0;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();

    // Fetch alone, then fetch racing a load.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    step();
    if_req_valid = 1'b0;
    step();
    if_req_addr  = 32'h4;
    if_req_valid = 1'b1;
    d_req_addr   = 32'h8;
    d_req_we     = 1'b0;
    d_req_valid  = 1'b1;
    step();
    d_req_valid = 1'b0;
    step();
    if_req_valid = 1'b0;
    step();

    // Sustained data traffic with fetch waiting: fetch must break through.
    if_req_valid = 1'b1;
    if_req_addr  = 32'hC;
    for (int k = 0; k < 12; k++) begin
      d_req_valid = 1'b1;
      d_req_we    = 1'b0;
      d_req_addr  = 32'(k % 4) << 2;
      step();
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();

    // Store/load forwarding, misaligned and out-of-range accesses.
    data_op(1'b1, 32'h50, 32'h5);
    data_op(1'b0, 32'h50, 32'h0);
    data_op(1'b1, 32'h52, 32'hFFFF_FFFF);
    data_op(1'b0, 32'h50, 32'h0);
    data_op(1'b0, 32'h3FC, 32'h0);
    data_op(1'b1, 32'h3F8, 32'hCAFE_F00D);
    data_op(1'b0, 32'h3F8, 32'h0);
    data_op(1'b1, 32'h400, 32'h1);
    step();
    check("mem20_kept", mem[20], 32'h5);

    // Reset right after a fetch grant drops the pending response.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    step();
    rst         = 1'b1;
    d_req_valid = 1'b1;
    step();
    step();
    rst          = 1'b0;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();

    // Random traffic; each requester holds its request until accepted.
    for (int k = 0; k < 200; k++) begin
      if (!if_req_valid || g_if) begin
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = rand_addr();
      end
      if (!d_req_valid || g_d) begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_req_addr  = rand_addr();
        d_req_we    = $urandom_range(0, 1) != 0;
        d_req_wdata = $urandom;
      end
      step();
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
